// File: rtl/ureg_pkg.sv
// Shared types for the universal register: operating-mode encoding and
// the shift-counter width helper used by the interface and the top.
package ureg_pkg;

  // Mode encoding as seen on the Mode port.
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    LOAD = 2'b01,
    SHL  = 2'b10,
    SHR  = 2'b11
  } ureg_mode_e;

  // Counter width for a given register width. It never drops below one
  // bit, so WIDTH=2 still gets a usable counter.
  function automatic int ureg_cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  // Default counter width for the default 8-bit register.
  localparam int UREG_CNT_W_DEFAULT = 3;

endpackage

// File: rtl/universal_reg_if.sv
// Signal bundle between the switch/key side (master) and the register
// (slave). Clock and reset stay as plain ports on the modules.
//
// Handshake: there is no valid/ready pair. En qualifies each rising edge:
// with En=1 the sampled Mode/D/SinL/SinR are consumed on that edge, and
// with En=0 the edge is ignored. The outputs are always valid. Q, ShCnt
// and Wrap show the result of the previous edge. SoutL and SoutR follow Q
// in the same cycle.
interface universal_reg_if
  import ureg_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int CNT_W = ureg_cnt_w(WIDTH);

  logic             En;
  logic [1:0]       Mode;
  logic [WIDTH-1:0] D;
  logic             SinL;
  logic             SinR;
  logic [WIDTH-1:0] Q;
  logic             SoutL;
  logic             SoutR;
  logic [CNT_W-1:0] ShCnt;
  logic             Wrap;

  modport master (
    output En, Mode, D, SinL, SinR,
    input  Q, SoutL, SoutR, ShCnt, Wrap
  );

  modport slave (
    input  En, Mode, D, SinL, SinR,
    output Q, SoutL, SoutR, ShCnt, Wrap
  );

endinterface

// File: rtl/ureg_cell.sv
// One storage bit of the universal register. A 4:1 next-state mux picks
// one of four sources: the bit itself, the parallel input, the lower
// neighbour (shift left) or the upper neighbour (shift right). The mux
// feeds an async-reset flop with its own reset value.
module ureg_cell
  import ureg_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  ureg_mode_e sel,
  input  logic       d_in,
  input  logic       shl_in,
  input  logic       shr_in,
  output logic       q
);

  logic q_d;
  logic q_q;

  // Next-state select; HOLD recirculates the current value.
  always_comb begin
    q_d = q_q;
    case (sel)
      HOLD:    q_d = q_q;
      LOAD:    q_d = d_in;
      SHL:     q_d = shl_in;
      SHR:     q_d = shr_in;
      default: q_d = q_q;
    endcase
  end

  // Storage flop; reset is asynchronous and takes effect without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/universal_reg.sv
// Edge-triggered universal register. It supports hold, parallel load,
// shift left and shift right, with serial ports at both ends. A shift
// counter runs modulo WIDTH and Wrap pulses for one cycle on every full
// WIDTH-bit shift.
//
// Build option: define UREG_ROTATE_EN to make both shift modes rotate.
// The bit leaving one end re-enters at the other, and SinL/SinR are
// ignored. Counter and Wrap behave the same, so Wrap then marks a full
// rotation.
module universal_reg
  import ureg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic            Clk,
  input  logic            Resetn,
  universal_reg_if.slave  io
);

  localparam int               CNT_W    = ureg_cnt_w(WIDTH);
  // Explicit terminal count so non-power-of-two widths wrap at WIDTH-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ureg_mode_e       mode_eff;
  logic [WIDTH-1:0] q_bits;
  logic             shl_fill;
  logic             shr_fill;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             wrap_d;
  logic             wrap_q;

  // En=0 collapses every mode to HOLD, so cells and counter see one mode.
  always_comb begin
    mode_eff = HOLD;
    if (io.En) begin
      mode_eff = ureg_mode_e'(io.Mode);
    end
  end

`ifdef UREG_ROTATE_EN
  // Rotation: the end bits feed each other, and the serial inputs go unused.
  logic unused_sin;
  assign unused_sin = io.SinL ^ io.SinR;
  assign shl_fill   = q_bits[WIDTH-1];
  assign shr_fill   = q_bits[0];
`else
  // Plain shift: the serial inputs fill the vacated end bit.
  assign shl_fill = io.SinL;
  assign shr_fill = io.SinR;
`endif

  // One cell per bit. Neighbour wiring turns the per-bit mux into a shift.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic shl_in;
    logic shr_in;

    if (i == 0) begin : g_shl_end
      assign shl_in = shl_fill;
    end else begin : g_shl_mid
      assign shl_in = q_bits[i-1];
    end

    if (i == WIDTH - 1) begin : g_shr_end
      assign shr_in = shr_fill;
    end else begin : g_shr_mid
      assign shr_in = q_bits[i+1];
    end

    ureg_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clk    (Clk),
      .rst_n  (Resetn),
      .sel    (mode_eff),
      .d_in   (io.D[i]),
      .shl_in (shl_in),
      .shr_in (shr_in),
      .q      (q_bits[i])
    );
  end

  // Shift counter: both shift directions increment, a load clears it, and
  // hold keeps it. Wrap is set only on the shift edge that rolls it over.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    case (mode_eff)
      LOAD: begin
        cnt_d = '0;
      end
      SHL, SHR: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Counter and Wrap flops share the register's asynchronous reset.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign io.Q     = q_bits;
  assign io.SoutL = q_bits[WIDTH-1];
  assign io.SoutR = q_bits[0];
  assign io.ShCnt = cnt_q;
  assign io.Wrap  = wrap_q;

endmodule

// File: tb/tb_universal_reg.sv
// Bench for universal_reg: an 8-bit instance (RESET_VAL=A5) and a 5-bit
// instance share one clock. Drivers push hand-computed expectations into a
// queue after each edge, and per-instance monitors pop and compare them on
// the falling edge. Expected packing is {SoutL, SoutR, Wrap, ShCnt, Q}.
module tb_universal_reg;
  import ureg_pkg::*;

`ifdef UREG_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  universal_reg_if #(.WIDTH(8)) io8();
  universal_reg_if #(.WIDTH(5)) io5();

  universal_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .Clk    (clk),
    .Resetn (rst_n),
    .io     (io8.slave)
  );

  universal_reg #(.WIDTH(5), .RESET_VAL(5'h00)) dut5 (
    .Clk    (clk),
    .Resetn (rst_n),
    .io     (io5.slave)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [13:0] exp8_q[$];
  string       name8_q[$];
  logic [10:0] exp5_q[$];
  string       name5_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] cur8();
    return {io8.SoutL, io8.SoutR, io8.Wrap, io8.ShCnt, io8.Q};
  endfunction

  function automatic logic [10:0] cur5();
    return {io5.SoutL, io5.SoutR, io5.Wrap, io5.ShCnt, io5.Q};
  endfunction

  // ---------------- driver tasks ----------------
  // Each call owns exactly one rising edge, so consecutive calls are
  // back-to-back cycles.
  task automatic step8(input logic en, input logic [1:0] mode, input logic [7:0] d,
                       input logic sl, input logic sr, input logic [7:0] eq,
                       input logic [2:0] ec, input logic ew, input string name);
    @(negedge clk);
    io8.En = en; io8.Mode = mode; io8.D = d; io8.SinL = sl; io8.SinR = sr;
    @(posedge clk);
    exp8_q.push_back({eq[7], eq[0], ew, ec, eq});
    name8_q.push_back(name);
  endtask

  task automatic step5(input logic en, input logic [1:0] mode, input logic [4:0] d,
                       input logic sl, input logic sr, input logic [4:0] eq,
                       input logic [2:0] ec, input logic ew, input string name);
    @(negedge clk);
    io5.En = en; io5.Mode = mode; io5.D = d; io5.SinL = sl; io5.SinR = sr;
    @(posedge clk);
    exp5_q.push_back({eq[4], eq[0], ew, ec, eq});
    name5_q.push_back(name);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (exp8_q.size() > 0) begin
      logic [13:0] e;
      string       n;
      e = exp8_q.pop_front();
      n = name8_q.pop_front();
      chk(n, {2'b00, cur8()}, {2'b00, e});
    end
  end

  always @(negedge clk) begin
    if (exp5_q.size() > 0) begin
      logic [10:0] e;
      string       n;
      e = exp5_q.pop_front();
      n = name5_q.pop_front();
      chk(n, {5'b0, cur5()}, {5'b0, e});
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] rot_tab[8];
  logic [7:0] wrap_tab[8];
  logic [4:0] w5_shl[5];
  logic [4:0] w5_shr[6];

  initial begin
    io8.En = 1'b0; io8.Mode = 2'b00; io8.D = '0; io8.SinL = 1'b0; io8.SinR = 1'b0;
    io5.En = 1'b0; io5.Mode = 2'b00; io5.D = '0; io5.SinL = 1'b0; io5.SinR = 1'b0;

    // Hand-computed shift sequences (plain shift vs rotate builds).
    wrap_tab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, ROT ? 8'h01 : 8'h00};
    if (ROT) rot_tab = '{8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4B, 8'h96};
    else     rot_tab = '{8'h2D, 8'h5A, 8'hB5, 8'h6A, 8'hD5, 8'hAA, 8'h55, 8'hAA};
    if (ROT) w5_shl = '{5'h02, 5'h04, 5'h08, 5'h10, 5'h01};
    else     w5_shl = '{5'h03, 5'h07, 5'h0F, 5'h1F, 5'h1F};
    if (ROT) w5_shr = '{5'h10, 5'h08, 5'h04, 5'h02, 5'h01, 5'h10};
    else     w5_shr = '{5'h0F, 5'h07, 5'h03, 5'h01, 5'h00, 5'h00};

    // Reset takes effect with no clock dependence.
    #1 rst_n = 1'b0;
    #11;
    chk("reset8", {2'b00, cur8()}, {2'b00, 1'b1, 1'b1, 1'b0, 3'd0, 8'hA5});
    chk("reset5", {5'b0, cur5()}, {5'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'h00});
    @(negedge clk);
    rst_n = 1'b1;

    // Load, then hold while D toggles, then En=0 with a shift mode.
    step8(1, 2'b01, 8'h3C, 0, 0, 8'h3C, 3'd0, 0, "load_3c");
    step8(1, 2'b00, 8'hFF, 1, 1, 8'h3C, 3'd0, 0, "hold_d_ff");
    step8(1, 2'b00, 8'h00, 0, 0, 8'h3C, 3'd0, 0, "hold_d_00");
    step8(1, 2'b00, 8'hFF, 1, 1, 8'h3C, 3'd0, 0, "hold_d_ff2");
    step8(1, 2'b00, 8'h00, 0, 0, 8'h3C, 3'd0, 0, "hold_d_002");
    step8(0, 2'b10, 8'h00, 1, 1, 8'h3C, 3'd0, 0, "en0_shl");
    step8(0, 2'b01, 8'h77, 1, 1, 8'h3C, 3'd0, 0, "en0_load");

    // Single shifts from 81 in each direction.
    step8(1, 2'b01, 8'h81, 0, 0, 8'h81, 3'd0, 0, "load_81");
    step8(1, 2'b10, 8'h00, 0, 0, ROT ? 8'h03 : 8'h02, 3'd1, 0, "shl_81");
    step8(1, 2'b01, 8'h81, 0, 0, 8'h81, 3'd0, 0, "load_81b");
    step8(1, 2'b11, 8'h00, 0, 1, 8'hC0, 3'd1, 0, "shr_81");

    // Eight consecutive shifts: ShCnt 1..7,0 and Wrap on the eighth only.
    step8(1, 2'b01, 8'h01, 0, 0, 8'h01, 3'd0, 0, "load_01");
    for (int i = 0; i < 8; i++) begin
      step8(1, 2'b10, 8'h00, 0, 0, wrap_tab[i], 3'((i + 1) % 8), (i == 7), $sformatf("wrap_shl%0d", i));
    end
    step8(1, 2'b00, 8'h00, 0, 0, wrap_tab[7], 3'd0, 0, "wrap_drop");

    // Mixed directions all count; a load mid-sequence clears without Wrap.
    step8(1, 2'b01, 8'h00, 0, 0, 8'h00, 3'd0, 0, "load_00");
    step8(1, 2'b10, 8'h00, 1, 0, ROT ? 8'h00 : 8'h01, 3'd1, 0, "mix_shl");
    step8(1, 2'b11, 8'h00, 0, 1, ROT ? 8'h00 : 8'h80, 3'd2, 0, "mix_shr");
    step8(1, 2'b10, 8'h00, 0, 0, 8'h00, 3'd3, 0, "mix_shl2");
    step8(1, 2'b01, 8'h5A, 0, 0, 8'h5A, 3'd0, 0, "mid_load");
    step8(1, 2'b11, 8'h00, 0, 0, 8'h2D, 3'd1, 0, "after_load_shr");
    step8(1, 2'b00, 8'h00, 0, 0, 8'h2D, 3'd1, 0, "after_load_hold");

    // Reset asserted mid-cycle while shifting.
    step8(1, 2'b10, 8'h00, 1, 0, ROT ? 8'h5A : 8'h5B, 3'd2, 0, "pre_rst1");
    step8(1, 2'b10, 8'h00, 1, 0, ROT ? 8'hB4 : 8'hB7, 3'd3, 0, "pre_rst2");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {2'b00, cur8()}, {2'b00, 1'b1, 1'b1, 1'b0, 3'd0, 8'hA5});
    @(negedge clk);
    chk("rst_held", {2'b00, cur8()}, {2'b00, 1'b1, 1'b1, 1'b0, 3'd0, 8'hA5});
    io8.Mode = 2'b10; io8.SinL = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    exp8_q.push_back({1'b0, ROT, 1'b0, 3'd1, ROT ? 8'h4B : 8'h4A});
    name8_q.push_back("first_edge_after_rst");
    step8(1, 2'b00, 8'h00, 0, 0, ROT ? 8'h4B : 8'h4A, 3'd1, 0, "post_rst_hold");

    // Eight left shifts of 96 with SinL toggling.
    step8(1, 2'b01, 8'h96, 0, 0, 8'h96, 3'd0, 0, "load_96");
    for (int i = 0; i < 8; i++) begin
      step8(1, 2'b10, 8'h00, ((i % 2) == 0), 0, rot_tab[i], 3'((i + 1) % 8), (i == 7), $sformatf("rot_shl%0d", i));
    end
    step8(1, 2'b00, 8'h00, 0, 0, rot_tab[7], 3'd0, 0, "rot_done");

    // Odd width: the counter wraps after five shifts and never passes 4.
    step5(1, 2'b01, 5'h01, 0, 0, 5'h01, 3'd0, 0, "w5_load");
    for (int i = 0; i < 5; i++) begin
      step5(1, 2'b10, 5'h00, 1, 0, w5_shl[i], 3'((i + 1) % 5), (i == 4), $sformatf("w5_shl%0d", i));
    end
    step5(1, 2'b00, 5'h00, 0, 0, w5_shl[4], 3'd0, 0, "w5_hold");
    for (int i = 0; i < 6; i++) begin
      step5(1, 2'b11, 5'h00, 0, 0, w5_shr[i], 3'((i + 1) % 5), (i == 4), $sformatf("w5_shr%0d", i));
    end
    step5(1, 2'b00, 5'h00, 0, 0, w5_shr[5], 3'd1, 0, "w5_end");

    // Drain the monitors, then report.
    repeat (3) @(negedge clk);
    #1;
    chk("queue8_drained", 16'(exp8_q.size()), 16'd0);
    chk("queue5_drained", 16'(exp5_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
